// File: rtl/legv8_pkg.sv
// legv8_pkg: shared definitions for the LEGv8 pipeline controller.
//   XZR          - the zero register; never a hazard or forwarding source
//   FWD_*        - ALU operand forwarding select encodings
//   ctrl_state_e - controller FSM states
//   reg_match    - true when a destination register really feeds a source
package legv8_pkg;

  localparam logic [4:0] XZR = 5'd31;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } ctrl_state_e;

  // A destination of XZR never produces a value, so it never matches a source.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != XZR) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// forward_unit: combinational ALU operand forwarding select for one operand.
// Ports:
//   rs              in  5 - source register of the instruction in ID/EX
//   exmem_rd        in  5 - destination held in EX/MEM
//   exmem_regwrite  in  1 - EX/MEM instruction writes back
//   memwb_rd        in  5 - destination held in MEM/WB
//   memwb_regwrite  in  1 - MEM/WB instruction writes back
//   fwd             out 2 - FWD_EXMEM, FWD_MEMWB or FWD_RF
module forward_unit
  import legv8_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_regwrite,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_regwrite,
  output logic [1:0] fwd
);

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd = FWD_RF;
    if (exmem_regwrite && reg_match(exmem_rd, rs)) begin
      fwd = FWD_EXMEM;
    end else if (memwb_regwrite && reg_match(memwb_rd, rs)) begin
      fwd = FWD_MEMWB;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/forwarding controller for the five-stage LEGv8
// pipeline. Sequences load-use stalls, taken-branch flushes resolved in MEM and
// data-memory wait states guarded by a timeout watchdog; keeps saturating
// performance counters.
// Parameters:
//   MEM_TIMEOUT - consecutive not-ready memory cycles before halting (>= 2)
//   CNT_W       - performance counter width
// Ports:
//   clock, reset (sync, active-high)
//   id_rn/id_rm, idex_rn/idex_rm/idex_rd, idex_memread  - hazard inputs
//   exmem_rd/memwb_rd, exmem_regwrite/memwb_regwrite     - forwarding inputs
//   exmem_branch, exmem_zero                             - branch resolution
//   dmem_req, dmem_ready                                 - data memory handshake
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en          - register enables
//   ifid_flush, idex_flush, exmem_flush                  - bubble insertion
//   pc_src, fwd_a, fwd_b                                 - datapath selects
//   halted, stall_cycles, flush_events                   - status / counters
module pipeline_ctrl
  import legv8_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic [4:0]       idex_rn,
  input  logic [4:0]       idex_rm,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic [4:0]       exmem_rd,
  input  logic [4:0]       memwb_rd,
  input  logic             exmem_regwrite,
  input  logic             memwb_regwrite,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_src,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  ctrl_state_e       state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  logic       busy_s;
  logic       freeze_s;
  logic       taken_s;
  logic       luse_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // An access with dmem_req dropped is treated as complete, so "busy" is the
  // single condition that both enters and holds the wait state.
  assign busy_s   = dmem_req & ~dmem_ready;
  assign freeze_s = ((state_r == ST_RUN) | (state_r == ST_MEM_WAIT)) & busy_s;
  assign taken_s  = exmem_branch & exmem_zero & ~freeze_s & (state_r != ST_HALT);
  assign luse_s   = idex_memread & (reg_match(idex_rd, id_rn) | reg_match(idex_rd, id_rm));

  forward_unit u_fwd_a (
    .rs             (idex_rn),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .fwd            (fwd_a_s)
  );

  forward_unit u_fwd_b (
    .rs             (idex_rm),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .fwd            (fwd_b_s)
  );

  // Pipeline register controls, priority reset > HALT > freeze > taken > luse.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_src      = 1'b0;
    fwd_a       = fwd_a_s;
    fwd_b       = fwd_b_s;
    if (reset) begin
      // Clear the pipeline contents while reset is held.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end else if (state_r == ST_HALT) begin
      pc_en = 1'b0;
    end else if (freeze_s) begin
      pc_en = 1'b0;
    end else if (taken_s) begin
      // Squash the three instructions fetched behind the branch.
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      pc_src      = 1'b1;
    end else if (luse_s) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX.
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  // Controller FSM with data-memory watchdog.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (busy_s) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= WAIT_ONE;
          end else begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (!busy_s) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r    <= ST_HALT;
            wait_cnt_r <= wait_cnt_r;
          end else begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
        end
        ST_HALT: begin
          state_r    <= ST_HALT;
          wait_cnt_r <= wait_cnt_r;
        end
        default: begin
          // An unreachable encoding is treated as a fault.
          state_r    <= ST_HALT;
          wait_cnt_r <= '0;
        end
      endcase
    end
  end

  // Saturating stall and flush performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if ((state_r != ST_HALT) && (freeze_s || luse_s) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (taken_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign halted       = (state_r == ST_HALT);
  assign stall_cycles = stall_cnt_r;
  assign flush_events = flush_cnt_r;

endmodule
